// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision add/subtract unit:
// FSM states, IEEE-754 constants and fflags bit positions.
package fp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND
   } state_e;

   localparam logic [31:0] CANONICAL_NAN = 32'h7FC00000;
   localparam int          EXP_BIAS      = 127;
   localparam int          EXP_MAX       = 255;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_lzc27.sv
// Leading-zero count of a 27-bit significand; an all-zero input reports 27.
module fp_lzc27 (
   input  logic [26:0] value_i,
   output logic [4:0]  count_o
);

   // Scanning upward lets the highest set bit make the last assignment.
   always_comb begin
      count_o = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (value_i[i]) count_o = 5'(26 - i);
      end
   end

endmodule

// File: rtl/fp_add_unit.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor (RNE) that feeds the
// FP register file write port: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
module fp_add_unit
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic [4:0]  rdIn,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rdOut,
   output logic [4:0]  flags
);

   localparam logic [7:0]        ExpAllOnes = 8'(EXP_MAX);
   localparam logic signed [9:0] ExpMaxS    = 10'(EXP_MAX);

   state_e             state_q, state_d;
   logic [31:0]        opA_q, opA_d, opB_q, opB_d;
   logic               op_q, op_d;
   logic [4:0]         rd_q, rd_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [26:0]        sigL_q, sigL_d, sigS_q, sigS_d;
   logic               effSub_q, effSub_d;
   logic               special_q, special_d;
   logic [31:0]        specialRes_q, specialRes_d;
   logic               specialNv_q, specialNv_d;
   logic [27:0]        sum_q, sum_d;
   logic [26:0]        mant_q, mant_d;
   logic               zero_q, zero_d;
   logic [31:0]        result_q, result_d;
   logic [4:0]         flags_q, flags_d;
   logic               done_q, done_d;

   logic               aSign, bSign, aNan, bNan, aInf, bInf, aSnan, bSnan, infInf, swapOps;
   logic [7:0]         aExp, bExp, lExp, sExp, expDiff;
   logic [22:0]        aFrac, bFrac;
   logic [26:0]        aSig, bSig, sSig, alignedS;
   logic [30:0]        aMag, bMag;
   logic [5:0]         shamt;
   logic [53:0]        shiftWide;
   logic [4:0]         lzCount;
   logic               roundUp, inexact;
   logic [24:0]        rounded;
   logic signed [9:0]  roundExp;
   logic [22:0]        roundFrac;

   // Operand unpacking and alignment; B carries the effective sign (sign XOR op).
   always_comb begin
      aSign     = opA_q[31];
      bSign     = opB_q[31] ^ op_q;
      aExp      = opA_q[30:23];
      bExp      = opB_q[30:23];
      aFrac     = opA_q[22:0];
      bFrac     = opB_q[22:0];
      aNan      = (aExp == ExpAllOnes) && (aFrac != 23'd0);
      bNan      = (bExp == ExpAllOnes) && (bFrac != 23'd0);
      aInf      = (aExp == ExpAllOnes) && (aFrac == 23'd0);
      bInf      = (bExp == ExpAllOnes) && (bFrac == 23'd0);
      aSnan     = aNan && !aFrac[22];
      bSnan     = bNan && !bFrac[22];
      infInf    = aInf && bInf && (aSign != bSign);
      aSig      = (aExp == 8'd0) ? 27'd0 : {1'b1, aFrac, 3'b000};
      bSig      = (bExp == 8'd0) ? 27'd0 : {1'b1, bFrac, 3'b000};
      aMag      = (aExp == 8'd0) ? 31'd0 : opA_q[30:0];
      bMag      = (bExp == 8'd0) ? 31'd0 : opB_q[30:0];
      swapOps   = bMag > aMag;
      lExp      = swapOps ? bExp : aExp;
      sExp      = swapOps ? aExp : bExp;
      sSig      = swapOps ? aSig : bSig;
      expDiff   = lExp - sExp;
      shamt     = (expDiff > 8'd27) ? 6'd27 : expDiff[5:0];
      shiftWide = {sSig, 27'd0} >> shamt;
      alignedS  = {shiftWide[53:28], shiftWide[27] | (|shiftWide[26:0])};
   end

   fp_lzc27 u_lzc (
      .value_i (sum_q[26:0]),
      .count_o (lzCount)
   );

   // Round-to-nearest-even on G/R/S; a carry out of the significand bumps the exponent.
   always_comb begin
      inexact   = |mant_q[2:0];
      roundUp   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
      rounded   = {1'b0, mant_q[26:3]} + {24'd0, roundUp};
      roundExp  = rounded[24] ? (exp_q + 10'sd1) : exp_q;
      roundFrac = rounded[24] ? rounded[23:1] : rounded[22:0];
   end

   // Next-state logic: each stage updates only the registers it owns.
   always_comb begin
      state_d      = state_q;
      opA_d        = opA_q;
      opB_d        = opB_q;
      op_d         = op_q;
      rd_d         = rd_q;
      sign_d       = sign_q;
      exp_d        = exp_q;
      sigL_d       = sigL_q;
      sigS_d       = sigS_q;
      effSub_d     = effSub_q;
      special_d    = special_q;
      specialRes_d = specialRes_q;
      specialNv_d  = specialNv_q;
      sum_d        = sum_q;
      mant_d       = mant_q;
      zero_d       = zero_q;
      result_d     = result_q;
      flags_d      = flags_q;
      done_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opA_d   = operandA;
               opB_d   = operandB;
               op_d    = op;
               rd_d    = rdIn;
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            sign_d      = swapOps ? bSign : aSign;
            exp_d       = $signed({2'b00, lExp});
            sigL_d      = swapOps ? bSig : aSig;
            sigS_d      = alignedS;
            effSub_d    = aSign ^ bSign;
            special_d   = aNan | bNan | aInf | bInf;
            specialNv_d = aSnan | bSnan | infInf;
            if (aNan || bNan || infInf) specialRes_d = CANONICAL_NAN;
            else if (aInf)              specialRes_d = {aSign, ExpAllOnes, 23'd0};
            else                        specialRes_d = {bSign, ExpAllOnes, 23'd0};
            state_d     = ADD;
         end
         ADD: begin
            sum_d   = effSub_q ? ({1'b0, sigL_q} - {1'b0, sigS_q})
                               : ({1'b0, sigL_q} + {1'b0, sigS_q});
            state_d = NORM;
         end
         NORM: begin
            zero_d = 1'b0;
            if (sum_q[27]) begin
               mant_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_d  = exp_q + 10'sd1;
            end else if (sum_q == 28'd0) begin
               // Cancellation of opposite signs yields +0; like-signed zeros keep their sign.
               zero_d = 1'b1;
               mant_d = 27'd0;
               sign_d = sign_q & ~effSub_q;
            end else begin
               mant_d = sum_q[26:0] << lzCount;
               exp_d  = exp_q - $signed({5'd0, lzCount});
            end
            state_d = ROUND;
         end
         ROUND: begin
            flags_d = 5'd0;
            if (special_q) begin
               result_d         = specialRes_q;
               flags_d[FLAG_NV] = specialNv_q;
            end else if (zero_q) begin
               result_d = {sign_q, 31'd0};
            end else if (roundExp <= 10'sd0) begin
               result_d         = {sign_q, 31'd0};
               flags_d[FLAG_UF] = 1'b1;
               flags_d[FLAG_NX] = 1'b1;
            end else if (roundExp >= ExpMaxS) begin
               result_d         = {sign_q, ExpAllOnes, 23'd0};
               flags_d[FLAG_OF] = 1'b1;
               flags_d[FLAG_NX] = 1'b1;
            end else begin
               result_d         = {sign_q, roundExp[7:0], roundFrac};
               flags_d[FLAG_NX] = inexact;
            end
            flags_d[FLAG_DZ] = 1'b0;
            done_d           = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         opA_q        <= 32'd0;
         opB_q        <= 32'd0;
         op_q         <= 1'b0;
         rd_q         <= 5'd0;
         sign_q       <= 1'b0;
         exp_q        <= 10'sd0;
         sigL_q       <= 27'd0;
         sigS_q       <= 27'd0;
         effSub_q     <= 1'b0;
         special_q    <= 1'b0;
         specialRes_q <= 32'd0;
         specialNv_q  <= 1'b0;
         sum_q        <= 28'd0;
         mant_q       <= 27'd0;
         zero_q       <= 1'b0;
         result_q     <= 32'd0;
         flags_q      <= 5'd0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         opA_q        <= opA_d;
         opB_q        <= opB_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         sign_q       <= sign_d;
         exp_q        <= exp_d;
         sigL_q       <= sigL_d;
         sigS_q       <= sigS_d;
         effSub_q     <= effSub_d;
         special_q    <= special_d;
         specialRes_q <= specialRes_d;
         specialNv_q  <= specialNv_d;
         sum_q        <= sum_d;
         mant_q       <= mant_d;
         zero_q       <= zero_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
         done_q       <= done_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign rdOut  = rd_q;
   assign flags  = flags_q;

endmodule
